vanilla_scoreboard_stall_profiler: RTL
======================================

Name: vanilla_scoreboard_stall_profiler

Overview:
- Downstream consumer of the vanilla scoreboard tracker's per-register int/float scoreboard info vectors.
- Each cycle the ID stage is stalled, attributes the stall to one scoreboard category: the pending long-latency op (idiv, fdiv/fsqrt, remote loads/AMOs) blocking a source operand.
- Also tracks peak outstanding remote int/float loads.
- Results are read by the testbench or profiler through a valid/ready/yumi readout port.

Parameters:
- counter_width_p, 32, width of every stall/peak counter (saturating).
- reg_els_p, 32, number of architectural registers per file (RV32_reg_els_gp).
- reg_addr_width_p, 5, register index width (RV32_reg_addr_width_gp).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  counting enable.
- clear_i  in  1  synchronous clear of all counters and peaks.
- stall_id  in  1  ID stage stalled.
- stall_all  in  1  whole pipeline stalled.
- flush  in  1  ID instruction being flushed.
- int_sb_i  in  reg_els_p x vanilla_isb_info_s  int scoreboard from the tracker.
- float_sb_i  in  reg_els_p x vanilla_fsb_info_s  float scoreboard from the tracker.
- rs1_i, rs2_i  in  reg_addr_width_p each  int source indices of the ID instruction.
- rs1_en_i, rs2_en_i  in  1 each  int sources read.
- frs1_i, frs2_i, frs3_i  in  reg_addr_width_p each  float source indices.
- frs1_en_i, frs2_en_i, frs3_en_i  in  1 each  float sources read.
- rd_v_i  in  1  readout request.
- rd_idx_i  in  4  counter index.
- rd_ready_o  out  1  request accepted when rd_v_i & rd_ready_o.
- rd_v_o  out  1  response valid.
- rd_data_o  out  counter_width_p  response data.
- rd_yumi_i  in  1  response consumed.

Behaviour:
- Reset (async, active-high): all counters, peaks and response regs = 0; FSM = IDLE; rd_ready_o=1, rd_v_o=0, rd_data_o=0.
- Stall cycle counted when en_i & stall_id & ~stall_all & ~flush.
- Hit vector: OR of the category flags over all enabled sources. Int register 0 never hits. Float register 0 is valid.
- Category index is the lowest set index among:
  - 0 int idiv
  - 1 int remote_dram_load
  - 2 int remote_dram_amo
  - 3 int remote_dmem_overflow_load
  - 4 int remote_global_load
  - 5 int remote_group_load
  - 6 int remote_group_amo
  - 7 float fdiv_fsqrt
  - 8 float remote_dram_load
  - 9 float remote_global_load
  - 10 float remote_group_load
  - 11 float remote_dmem_overflow_load
- Exactly one counter increments per counted cycle: the selected category, or index 12 ("other") if no hit.
- Counters saturate at all-ones.
- int_out = count of registers 1..reg_els_p-1 with any int flag except idiv set. float_out = count of registers with any float flag except fdiv_fsqrt set.
- Peaks: index 13 (int) and 14 (float), updated every cycle when en_i: peak <= max(peak, out), zero-extended.
- clear_i zeroes all 15 entries and overrides any same-cycle increment or peak update. clear_i does not affect the FSM.
- Readout FSM:
  - IDLE: rd_ready_o=1. On rd_v_i, latch the entry's pre-update value from that cycle (0 if idx>=15) into rd_data_o; go to RESP.
  - RESP: rd_ready_o=0, rd_v_o=1, rd_data_o held stable until rd_yumi_i, then go to IDLE. No back-to-back acceptance in the yumi cycle.
- Counting continues independently of readout.
- Reset asserted mid-RESP returns the FSM to IDLE immediately, with rd_v_o=0.

Test Plan:
- Reset, then read indices 0..15 -> every response is 0; each response arrives the cycle after acceptance.
- int_sb_i[5].remote_dram_load=1 and .idiv=1, rs1_i=5, rs1_en_i=1, 10 counted stall cycles -> idx0=10, idx1=0, idx12=0.
- rs1_i=0 with int_sb_i[0] flags set, 3 stall cycles; then 2 cycles with stall_all=1 -> idx12=3, nothing else changes.
- float_sb_i[0].remote_group_load=1, frs3_i=0, frs3_en_i=1, 4 stall cycles -> idx10=4.
- Scoreboard rises to 7 int and 3 float outstanding loads, then drops to 0 -> idx13=7, idx14=3. clear_i in the same cycle as a counted stall -> all entries read 0.
- Hold rd_yumi_i=0 for 5 cycles while counts change -> rd_data_o stable. Force a counter to all-ones, stall once more -> reads all-ones. Assert reset_i in RESP -> rd_v_o drops asynchronously.

Source files
------------

// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Attributes counted ID-stage stall cycles to the blocking scoreboard category and tracks peak outstanding remote loads.
// Readout takes one cycle from acceptance to rd_v_o; the response holds until rd_yumi_i, and no request is accepted meanwhile.
package vanilla_sb_profiler_pkg;

  typedef struct packed {
    logic idiv;
    logic remote_dram_load;
    logic remote_dram_amo;
    logic remote_dmem_overflow_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_group_amo;
  } vanilla_isb_info_s;

  typedef struct packed {
    logic fdiv_fsqrt;
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_dmem_overflow_load;
  } vanilla_fsb_info_s;

endpackage

module vanilla_scoreboard_stall_profiler
  import vanilla_sb_profiler_pkg::*;
#(
  parameter int counter_width_p  = 32,
  parameter int reg_els_p        = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 en_i,
  input  logic                                 clear_i,
  input  logic                                 stall_id,
  input  logic                                 stall_all,
  input  logic                                 flush,
  input  vanilla_isb_info_s [reg_els_p-1:0]    int_sb_i,
  input  vanilla_fsb_info_s [reg_els_p-1:0]    float_sb_i,
  input  logic [reg_addr_width_p-1:0]          rs1_i,
  input  logic [reg_addr_width_p-1:0]          rs2_i,
  input  logic                                 rs1_en_i,
  input  logic                                 rs2_en_i,
  input  logic [reg_addr_width_p-1:0]          frs1_i,
  input  logic [reg_addr_width_p-1:0]          frs2_i,
  input  logic [reg_addr_width_p-1:0]          frs3_i,
  input  logic                                 frs1_en_i,
  input  logic                                 frs2_en_i,
  input  logic                                 frs3_en_i,
  input  logic                                 rd_v_i,
  input  logic [3:0]                           rd_idx_i,
  output logic                                 rd_ready_o,
  output logic                                 rd_v_o,
  output logic [counter_width_p-1:0]           rd_data_o,
  input  logic                                 rd_yumi_i
);

  localparam int num_entries_lp     = 15;
  localparam int num_cats_lp        = 12;
  localparam int other_idx_lp       = 12;
  localparam int int_peak_idx_lp    = 13;
  localparam int float_peak_idx_lp  = 14;

  typedef enum logic {IDLE, RESP} rd_state_e;

  // Bit 0 is idiv so the category numbering matches the int half of the hit vector.
  function automatic logic [6:0] isb_bits(input vanilla_isb_info_s s);
    return {s.remote_group_amo, s.remote_group_load, s.remote_global_load,
            s.remote_dmem_overflow_load, s.remote_dram_amo, s.remote_dram_load, s.idiv};
  endfunction

  function automatic logic [4:0] fsb_bits(input vanilla_fsb_info_s s);
    return {s.remote_dmem_overflow_load, s.remote_group_load, s.remote_global_load,
            s.remote_dram_load, s.fdiv_fsqrt};
  endfunction

  function automatic logic isb_remote(input vanilla_isb_info_s s);
    return s.remote_dram_load | s.remote_dram_amo | s.remote_dmem_overflow_load |
           s.remote_global_load | s.remote_group_load | s.remote_group_amo;
  endfunction

  function automatic logic fsb_remote(input vanilla_fsb_info_s s);
    return s.remote_dram_load | s.remote_global_load | s.remote_group_load |
           s.remote_dmem_overflow_load;
  endfunction

  logic [counter_width_p-1:0] entries_q [num_entries_lp];
  logic [counter_width_p-1:0] entries_d [num_entries_lp];
  logic [num_cats_lp-1:0]     hit;
  logic [3:0]                 sel;
  logic                       count_en;
  logic [counter_width_p-1:0] int_out;
  logic [counter_width_p-1:0] float_out;
  logic [counter_width_p-1:0] rd_sel;
  logic [counter_width_p-1:0] data_q, data_d;
  rd_state_e                  state_q, state_d;

  assign count_en = en_i & stall_id & ~stall_all & ~flush;

  // x0 is hardwired so its scoreboard entry is ignored; f0 is a real register.
  always_comb begin
    hit = '0;
    if (rs1_en_i && (rs1_i != '0)) hit[6:0] = hit[6:0] | isb_bits(int_sb_i[rs1_i]);
    if (rs2_en_i && (rs2_i != '0)) hit[6:0] = hit[6:0] | isb_bits(int_sb_i[rs2_i]);
    if (frs1_en_i) hit[11:7] = hit[11:7] | fsb_bits(float_sb_i[frs1_i]);
    if (frs2_en_i) hit[11:7] = hit[11:7] | fsb_bits(float_sb_i[frs2_i]);
    if (frs3_en_i) hit[11:7] = hit[11:7] | fsb_bits(float_sb_i[frs3_i]);
  end

  always_comb begin
    sel = 4'(other_idx_lp);
    for (int i = num_cats_lp - 1; i >= 0; i--) begin
      if (hit[i]) sel = 4'(i);
    end
  end

  always_comb begin
    int_out   = '0;
    float_out = '0;
    for (int r = 1; r < reg_els_p; r++) begin
      int_out = int_out + counter_width_p'(isb_remote(int_sb_i[r]));
    end
    for (int r = 0; r < reg_els_p; r++) begin
      float_out = float_out + counter_width_p'(fsb_remote(float_sb_i[r]));
    end
  end

  always_comb begin
    for (int i = 0; i < num_entries_lp; i++) entries_d[i] = entries_q[i];
    if (count_en && (entries_q[sel] != '1)) entries_d[sel] = entries_q[sel] + 1'b1;
    if (en_i) begin
      if (int_out > entries_q[int_peak_idx_lp])     entries_d[int_peak_idx_lp]   = int_out;
      if (float_out > entries_q[float_peak_idx_lp]) entries_d[float_peak_idx_lp] = float_out;
    end
    if (clear_i) begin
      for (int i = 0; i < num_entries_lp; i++) entries_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_entries_lp; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < num_entries_lp; i++) entries_q[i] <= entries_d[i];
    end
  end

  // Unmapped indices read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < num_entries_lp; i++) begin
      if (rd_idx_i == 4'(i)) rd_sel = entries_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rd_ready_o = 1'b0;
    rd_v_o     = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ready_o = 1'b1;
        if (rd_v_i) begin
          data_d  = rd_sel;
          state_d = RESP;
        end
      end
      RESP: begin
        rd_v_o = 1'b1;
        if (rd_yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule
